// File: rtl/conv_pkg.sv
// Shared definitions for the frame convolution controller: state encoding,
// default window geometry and the counter-width helper.
package conv_pkg;

  // Controller states. The encoding is fixed so it stays compatible with
  // tools and scripts that use the raw 2-bit values.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_ROW_UP = 2'd2,
    ST_DRAIN  = 2'd3
  } conv_state_e;

  // Default geometry.
  localparam int RAM_SR_DEPTH_DEF  = 4;
  localparam int NUM_SR_ROWS_DEF   = 4;
  localparam int OUT_ROWS_DEF      = 2;
  localparam int MA_TREE_DEPTH_DEF = 4;

  // Bits needed to count 0..value-1. Never returns less than 1, so that
  // degenerate geometries still get a legal vector.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/conv_frame_fsm_if.sv
// Handshake and control bundle between the frame controller and its datapath.
// The slave modport is the controller's view; the master modport is the view
// of whatever drives the requests and the downstream ready.
interface conv_frame_fsm_if #(
  parameter int OUT_ROWS = conv_pkg::OUT_ROWS_DEF
);
  localparam int OR_W = conv_pkg::clog2_min1(OUT_ROWS);

  logic            input_start;
  logic            row_shift_in_rdy;
  logic            conv_ready;
  logic            sr_enable;
  logic            shift_row_up;
  logic            window_valid;
  logic            tree_advance;
  logic            conv_valid;
  logic [OR_W-1:0] out_row_idx;
  logic            conv_done;
  logic            busy;

  modport slave (
    input  input_start, row_shift_in_rdy, conv_ready,
    output sr_enable, shift_row_up, window_valid, tree_advance,
           conv_valid, out_row_idx, conv_done, busy
  );

  modport master (
    output input_start, row_shift_in_rdy, conv_ready,
    input  sr_enable, shift_row_up, window_valid, tree_advance,
           conv_valid, out_row_idx, conv_done, busy
  );

endinterface

// File: rtl/conv_valid_pipe.sv
// Valid-token pipeline that shadows the multiply-add tree. DEPTH registers in
// total; the last one is the output stage and doubles as conv_valid. The whole
// pipe only moves when the output stage is empty or being accepted, so a held
// result freezes everything behind it and an exiting token can replace an
// accepted result in the same cycle.
module conv_valid_pipe #(
  parameter int DEPTH = conv_pkg::MA_TREE_DEPTH_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic token_in,
  input  logic conv_ready,
  output logic tree_advance,
  output logic conv_valid
);

  logic [DEPTH-1:0] stage_reg;
  logic [DEPTH-1:0] stage_next;

  assign stage_next[0] = token_in;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_stage
      assign stage_next[gi] = stage_reg[gi-1];
    end
  endgenerate

  assign conv_valid   = stage_reg[DEPTH-1];
  assign tree_advance = !conv_valid || conv_ready;

  // Shift all stages together whenever the tree is allowed to advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_reg <= '0;
    end else if (tree_advance) begin
      stage_reg <= stage_next;
    end
  end

endmodule

// File: rtl/conv_frame_fsm.sv
// Frame sequencer for the row shift-register / multiply-add tree datapath.
// Loads NUM_SR_ROWS rows for the first window, then one extra row per further
// output row, and hands results downstream on a valid/ready handshake whose
// backpressure stalls both column shifting and the tree.
module conv_frame_fsm
  import conv_pkg::*;
#(
  parameter int RAM_SR_DEPTH  = RAM_SR_DEPTH_DEF,
  parameter int NUM_SR_ROWS   = NUM_SR_ROWS_DEF,
  parameter int OUT_ROWS      = OUT_ROWS_DEF,
  parameter int MA_TREE_DEPTH = MA_TREE_DEPTH_DEF
) (
  input logic             clock,
  input logic             reset,
  conv_frame_fsm_if.slave bus
);

  localparam int COL_W = clog2_min1(RAM_SR_DEPTH);
  localparam int ROW_W = clog2_min1(NUM_SR_ROWS + OUT_ROWS);
  localparam int OR_W  = clog2_min1(OUT_ROWS);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] SHIFT  = ST_SHIFT;
  localparam logic [1:0] ROW_UP = ST_ROW_UP;
  localparam logic [1:0] DRAIN  = ST_DRAIN;

  // Last column of a row, first row that completes a full window, last row
  // of the frame, and index of the final output row.
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(RAM_SR_DEPTH - 1);
  localparam logic [ROW_W-1:0] WIN_FIRST = ROW_W'(NUM_SR_ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(NUM_SR_ROWS + OUT_ROWS - 2);
  localparam logic [OR_W-1:0]  IDX_LAST  = OR_W'(OUT_ROWS - 1);

  logic [1:0]       state_reg, state_next;
  logic [COL_W-1:0] col_cnt_reg, col_cnt_next;
  logic [ROW_W-1:0] row_cnt_reg, row_cnt_next;
  logic [OR_W-1:0]  idx_reg;
  logic             done_reg;

  logic tree_advance;
  logic conv_valid;
  logic sr_enable;
  logic row_complete;
  logic window_valid;
  logic handshake;
  logic final_handshake;

  conv_valid_pipe #(
    .DEPTH(MA_TREE_DEPTH)
  ) u_valid_pipe (
    .clock       (clock),
    .reset       (reset),
    .token_in    (window_valid),
    .conv_ready  (bus.conv_ready),
    .tree_advance(tree_advance),
    .conv_valid  (conv_valid)
  );

  assign sr_enable       = (state_reg == SHIFT) && bus.row_shift_in_rdy && tree_advance;
  assign row_complete    = sr_enable && (col_cnt_reg == COL_LAST);
  assign window_valid    = row_complete && (row_cnt_reg >= WIN_FIRST);
  assign handshake       = conv_valid && bus.conv_ready;
  assign final_handshake = handshake && (idx_reg == IDX_LAST);

  assign bus.sr_enable    = sr_enable;
  assign bus.shift_row_up = (state_reg == ROW_UP);
  assign bus.window_valid = window_valid;
  assign bus.tree_advance = tree_advance;
  assign bus.conv_valid   = conv_valid;
  assign bus.out_row_idx  = idx_reg;
  assign bus.conv_done    = done_reg;
  assign bus.busy         = (state_reg != IDLE);

  // Next state and column/row counters; the final handshake always wins and
  // closes the frame.
  always_comb begin
    state_next   = state_reg;
    col_cnt_next = col_cnt_reg;
    row_cnt_next = row_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.input_start) begin
          state_next   = SHIFT;
          col_cnt_next = '0;
          row_cnt_next = '0;
        end
      end
      SHIFT: begin
        if (row_complete) begin
          col_cnt_next = '0;
          row_cnt_next = row_cnt_reg + 1'b1;
          state_next   = (row_cnt_reg == ROW_LAST) ? DRAIN : ROW_UP;
        end else if (sr_enable) begin
          col_cnt_next = col_cnt_reg + 1'b1;
        end
      end
      ROW_UP: begin
        state_next = SHIFT;
      end
      DRAIN: begin
        state_next = DRAIN;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (final_handshake) begin
      state_next = IDLE;
    end
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      col_cnt_reg <= col_cnt_next;
      row_cnt_reg <= row_cnt_next;
    end
  end

  // Output-row index follows accepted results; the done pulse marks the
  // cycle after the last row is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= final_handshake;
      if (final_handshake) begin
        idx_reg <= '0;
      end else if (handshake) begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

endmodule

// File: doc/conv_frame_fsm.md
Name: conv_frame_fsm

Overview:
- Parametrised successor to the single-window convolution controller.
- Sequences a full frame of OUT_ROWS output rows through the row shift-register / multiply-add tree datapath.
- Sliding window: NUM_SR_ROWS rows are loaded for the first output, then one new row per subsequent output.
- Tracks the adder-tree latency with a valid pipeline and presents results on a valid/ready handshake with backpressure that stalls shifting and the tree.

Parameters:
RAM_SR_DEPTH, 4, column shifts needed to load one row into the row shift register
NUM_SR_ROWS, 4, kernel rows (window height)
OUT_ROWS, 2, output rows per frame (frame loads NUM_SR_ROWS+OUT_ROWS-1 rows)
MA_TREE_DEPTH, 4, pipeline latency of multiply-add tree in advancing cycles
COL_W / ROW_W / OR_W, derived localparams, clog2 widths of the column, row and output-row counters (minimum 1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
input_start  in  1  frame start request, sampled only in IDLE
row_shift_in_rdy  in  1  upstream row data available; low stalls column shifting
conv_ready  in  1  downstream accepts result
sr_enable  out  1  shift row shift register by one column
shift_row_up  out  1  move stored rows up one position
window_valid  out  1  window complete; tree should capture it
tree_advance  out  1  multiply-add tree pipeline enable
conv_valid  out  1  tree result valid
out_row_idx  out  OR_W  index of the output row currently presented on conv_valid
conv_done  out  1  one-cycle pulse: frame complete
busy  out  1  frame in progress

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - All counters, the valid pipeline and out_row_idx clear to 0.
  - All outputs read 0, except tree_advance, which reads 1.
  - Reset mid-frame abandons the frame and no conv_done is issued.
- tree_advance = !conv_valid || conv_ready (combinational). The valid pipeline and the output stage move only when tree_advance=1.
- States: IDLE, SHIFT, ROW_UP, DRAIN.
- IDLE:
  - busy=0.
  - input_start=1 → SHIFT next cycle, with col_cnt=0, row_cnt=0, issued=0.
- SHIFT:
  - busy=1.
  - sr_enable = row_shift_in_rdy && tree_advance.
  - col_cnt increments on each sr_enable cycle and holds while stalled.
  - Row complete: sr_enable && col_cnt==RAM_SR_DEPTH-1. On that cycle col_cnt wraps to 0 and row_cnt increments.
  - window_valid = row complete && row_cnt>=NUM_SR_ROWS-1. It pushes a token into the MA_TREE_DEPTH-stage valid pipeline.
  - After row complete: go to DRAIN if the row just completed is row NUM_SR_ROWS+OUT_ROWS-2; otherwise go to ROW_UP.
- ROW_UP:
  - Exactly one cycle, shift_row_up=1, unconditional.
  - Then back to SHIFT.
- DRAIN:
  - busy=1, no shifting.
  - Waits for the final handshake.
- Output stage:
  - conv_valid is set when a token exits the pipeline.
  - conv_valid holds until conv_valid && conv_ready.
  - out_row_idx increments on each handshake.
- Frame end:
  - The handshake with out_row_idx==OUT_ROWS-1 sends the FSM to IDLE next cycle.
  - conv_done=1 for that one cycle, busy=0, out_row_idx reset to 0.
- Latency: a token pushed at cycle t gives conv_valid=1 at cycle t+MA_TREE_DEPTH, provided tree_advance stays 1.
- Boundaries:
  - input_start while busy is ignored.
  - OUT_ROWS=1: a single window, then DRAIN.
  - row_shift_in_rdy low on the last-column cycle defers row completion (and window_valid) until rdy returns.
  - conv_ready low with conv_valid=1 freezes the pipeline and sr_enable. ROW_UP still completes its one cycle.
  - Simultaneous token exit and handshake: the new result replaces the old with no bubble.

Decomposition:
- Shared package conv_pkg holds:
  - the state enum (IDLE/SHIFT/ROW_UP/DRAIN);
  - default geometry constants;
  - a clog2-with-minimum-1 function for counter widths.
- One natural sub-module: conv_valid_pipe. It is a MA_TREE_DEPTH-deep valid shift register with enable, with output held until handshake.

Test Plan:
- Defaults, conv_ready=1, rdy=1, input_start pulsed at cycle 0:
  - sr_enable in cycles 1-4, 6-9, 11-14, 16-19, 21-24;
  - shift_row_up at 5, 10, 15, 20;
  - window_valid at 19 and 24; conv_valid at 23 and 28;
  - conv_done at 29, busy=0 at 29.
- Same run with row_shift_in_rdy=0 during cycles 7-8:
  - col_cnt holds; all later events shift by +2 cycles; conv_done at 31.
- conv_ready=0 from cycle 23 for 3 cycles:
  - conv_valid held with out_row_idx=0;
  - sr_enable and tree_advance low during the stall;
  - second result delivered in order; conv_done only after its handshake.
- Reset asserted at cycle 12 mid-frame:
  - immediate IDLE, all outputs 0, no conv_done;
  - a fresh input_start restarts at row 0.
- OUT_ROWS=1, NUM_SR_ROWS=2, RAM_SR_DEPTH=2:
  - one window_valid at cycle 5, conv_valid at 9, conv_done at 10.
- input_start pulsed again at cycle 10 while busy: no effect on counters or timing.
